// File: rtl/pc_gen_btb_pkg.sv
// Shared types for the fetch PC generator: BTB entry layout and the 2-bit
// saturating direction counter.
package pc_gen_pkg;

    localparam int XLEN = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;
    localparam ctr_t CTR_WNT = 2'd1;
    localparam ctr_t CTR_WT  = 2'd2;
    localparam ctr_t CTR_ST  = 2'd3;

    // tag/target are held at full XLEN width; narrower tags are zero-extended
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        ctr_t            ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
        else       return (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/pc_gen_btb_if.sv
// Fetch-control bundle between the pipeline (master) and the PC generator
// (slave): redirect sources, BTB update port and the fetch PC outputs.
interface pc_gen_btb_if #(parameter int XLEN = pc_gen_pkg::XLEN);

    logic            i_stall_f;
    logic            i_trap_valid;
    logic [XLEN-1:0] i_trap_pc;
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            i_upd_valid;
    logic [XLEN-1:0] i_upd_pc;
    logic            i_upd_taken;
    logic [XLEN-1:0] i_upd_target;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_four;
    logic            o_pred_taken;
    logic [XLEN-1:0] o_pred_target;

    modport master (
        output i_stall_f, i_trap_valid, i_trap_pc, i_redirect_valid, i_redirect_pc,
               i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
        input  o_pc, o_pc_four, o_pred_taken, o_pred_target
    );

    modport slave (
        input  i_stall_f, i_trap_valid, i_trap_pc, i_redirect_valid, i_redirect_pc,
               i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target,
        output o_pc, o_pc_four, o_pred_taken, o_pred_target
    );

endinterface

// File: rtl/pc_gen_btb_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup port, registered
// update port. A same-cycle update is only visible to lookups on the next cycle.
module btb_dm
    import pc_gen_pkg::*;
#(
    parameter int XLEN        = pc_gen_pkg::XLEN,
    parameter int BTB_ENTRIES = 16,
    parameter int INSTR_BYTES = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_lkp_pc,
    output logic            o_lkp_taken,
    output logic [XLEN-1:0] o_lkp_target,
    input  logic            i_upd_valid,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target
);

    localparam int OFF_W = $clog2(INSTR_BYTES);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - OFF_W - IDX_W;
    localparam int ENT_W = pc_gen_pkg::XLEN;

    btb_entry_t mem_q [BTB_ENTRIES];
    btb_entry_t rd_ent;
    btb_entry_t upd_old;
    btb_entry_t upd_d;
    logic       upd_hit;
    logic       upd_we;

    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;

    assign lkp_idx = i_lkp_pc[OFF_W+IDX_W-1:OFF_W];
    assign lkp_tag = i_lkp_pc[XLEN-1:OFF_W+IDX_W];
    assign upd_idx = i_upd_pc[OFF_W+IDX_W-1:OFF_W];
    assign upd_tag = i_upd_pc[XLEN-1:OFF_W+IDX_W];

    // instruction-offset bits play no part in indexing or tagging
    logic unused_off;
    assign unused_off = ^{i_lkp_pc[OFF_W-1:0], i_upd_pc[OFF_W-1:0]};

    assign rd_ent       = mem_q[lkp_idx];
    assign o_lkp_taken  = rd_ent.valid && (rd_ent.tag == ENT_W'(lkp_tag)) && rd_ent.ctr[1];
    assign o_lkp_target = XLEN'(rd_ent.target);

    assign upd_old = mem_q[upd_idx];
    assign upd_hit = upd_old.valid && (upd_old.tag == ENT_W'(upd_tag));

    always_comb begin
        upd_we = 1'b0;
        upd_d  = upd_old;
        if (upd_hit) begin
            upd_we    = 1'b1;
            upd_d.ctr = ctr_next(upd_old.ctr, i_upd_taken);
            if (i_upd_taken) upd_d.target = ENT_W'(i_upd_target);
        end else if (i_upd_taken) begin
            upd_we       = 1'b1;
            upd_d.valid  = 1'b1;
            upd_d.tag    = ENT_W'(upd_tag);
            upd_d.target = ENT_W'(i_upd_target);
            upd_d.ctr    = CTR_WT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) mem_q[i] <= '0;
        end else if (i_upd_valid && upd_we) begin
            mem_q[upd_idx] <= upd_d;
        end
    end

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch-stage PC generator: PC register with prioritised next-PC selection
// (trap > EX redirect > stall > BTB prediction > sequential).
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = pc_gen_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 16,
    parameter int              INSTR_BYTES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    pc_gen_btb_if.slave  bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_four;
    logic [XLEN-1:0] btb_target;
    logic            pred_taken;

    btb_dm #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_btb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_lkp_pc     (pc_q),
        .o_lkp_taken  (pred_taken),
        .o_lkp_target (btb_target),
        .i_upd_valid  (bus.i_upd_valid),
        .i_upd_pc     (bus.i_upd_pc),
        .i_upd_taken  (bus.i_upd_taken),
        .i_upd_target (bus.i_upd_target)
    );

    assign pc_four = pc_q + XLEN'(INSTR_BYTES);

    always_comb begin
        pc_d = pc_four;
        if (bus.i_trap_valid)          pc_d = bus.i_trap_pc;
        else if (bus.i_redirect_valid) pc_d = bus.i_redirect_pc;
        else if (bus.i_stall_f)        pc_d = pc_q;
        else if (pred_taken)           pc_d = btb_target;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) pc_q <= RESET_VEC;
        else        pc_q <= pc_d;
    end

    assign bus.o_pc          = pc_q;
    assign bus.o_pc_four     = pc_four;
    assign bus.o_pred_taken  = pred_taken;
    assign bus.o_pred_target = pred_taken ? btb_target : pc_four;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Bench for pc_gen_btb: directed vector table, hand-written corner sequences,
// then randomized traffic against an array-based reference model.
module tb_pc_gen_btb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_gen_btb_if #(.XLEN(32)) bus ();

    pc_gen_btb #(
        .XLEN        (32),
        .RESET_VEC   (32'h0000_0000),
        .BTB_ENTRIES (16),
        .INSTR_BYTES (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic stall, input logic tv, input logic [31:0] tpc,
                         input logic rv, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt);
        bus.i_stall_f        = stall;
        bus.i_trap_valid     = tv;
        bus.i_trap_pc        = tpc;
        bus.i_redirect_valid = rv;
        bus.i_redirect_pc    = rpc;
        bus.i_upd_valid      = uv;
        bus.i_upd_pc         = upc;
        bus.i_upd_taken      = ut;
        bus.i_upd_target     = utgt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        tv;
        logic [31:0] tpc;
        logic        rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] exp_pc;
        logic        exp_pt;
        logic [31:0] exp_tgt;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    // Reference model: BTB as plain arrays, index/tag by integer division
    logic [31:0] m_pc;
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] mtag(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit mpred();
        int i;
        i = midx(m_pc);
        return m_valid[i] && (m_tag[i] == mtag(m_pc)) && (m_ctr[i] >= 2);
    endfunction

    task automatic model_step(input logic stall, input logic tv, input logic [31:0] tpc,
                              input logic rv, input logic [31:0] rpc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt);
        logic [31:0] nxt;
        int i;
        if (tv)          nxt = tpc;
        else if (rv)     nxt = rpc;
        else if (stall)  nxt = m_pc;
        else if (mpred()) nxt = m_tgt[midx(m_pc)];
        else             nxt = m_pc + 32'd4;
        if (uv) begin
            i = midx(upc);
            if (m_valid[i] && m_tag[i] == mtag(upc)) begin
                if (ut) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = utgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[i] = 1;
                m_tag[i]   = mtag(upc);
                m_tgt[i]   = utgt;
                m_ctr[i]   = 2;
            end
        end
        m_pc = nxt;
    endtask

    initial begin
        //        stall tv tpc    rv rpc     uv upc    ut utgt     exp_pc  pt exp_tgt
        vecs[0]  = '{0, 0, 0,     0, 0,      0, 0,     0, 0,       32'h00, 0, 32'h04};
        vecs[1]  = '{0, 0, 0,     0, 0,      0, 0,     0, 0,       32'h04, 0, 32'h08};
        vecs[2]  = '{1, 0, 0,     0, 0,      0, 0,     0, 0,       32'h08, 0, 32'h0C};
        vecs[3]  = '{1, 0, 0,     1, 32'h100, 0, 0,    0, 0,       32'h08, 0, 32'h0C};
        vecs[4]  = '{0, 1, 32'h80, 1, 32'h200, 0, 0,   0, 0,       32'h100, 0, 32'h104};
        vecs[5]  = '{0, 0, 0,     1, 32'h10, 1, 32'h10, 1, 32'h40, 32'h80, 0, 32'h84};
        vecs[6]  = '{0, 0, 0,     0, 0,      0, 0,     0, 0,       32'h10, 1, 32'h40};
        vecs[7]  = '{0, 0, 0,     1, 32'h10, 1, 32'h10, 0, 0,      32'h40, 0, 32'h44};
        vecs[8]  = '{0, 0, 0,     0, 0,      1, 32'h10, 0, 0,      32'h10, 0, 32'h14};
        vecs[9]  = '{0, 0, 0,     1, 32'h10, 1, 32'h10, 0, 0,      32'h14, 0, 32'h18};
        vecs[10] = '{0, 0, 0,     1, 32'h10, 1, 32'h10, 1, 32'h44, 32'h10, 0, 32'h14};
        vecs[11] = '{0, 0, 0,     1, 32'h10, 1, 32'h10, 1, 32'h44, 32'h10, 0, 32'h14};
        vecs[12] = '{0, 0, 0,     1, 32'h10, 1, 32'h50, 1, 32'h90, 32'h10, 1, 32'h44};
        vecs[13] = '{0, 0, 0,     1, 32'h50, 0, 0,     0, 0,       32'h10, 0, 32'h14};
        vecs[14] = '{0, 0, 0,     0, 0,      0, 0,     0, 0,       32'h50, 1, 32'h90};
        vecs[15] = '{0, 0, 0,     0, 0,      0, 0,     0, 0,       32'h90, 0, 32'h94};

        do_reset();

        for (int v = 0; v < NVEC; v++) begin
            chk($sformatf("vec%0d pc", v), bus.o_pc, vecs[v].exp_pc);
            chk($sformatf("vec%0d pred_taken", v), 32'(bus.o_pred_taken), 32'(vecs[v].exp_pt));
            chk($sformatf("vec%0d pred_target", v), bus.o_pred_target, vecs[v].exp_tgt);
            drive(vecs[v].stall, vecs[v].tv, vecs[v].tpc, vecs[v].rv, vecs[v].rpc,
                  vecs[v].uv, vecs[v].upc, vecs[v].ut, vecs[v].utgt);
            tick();
        end
        idle();
        chk("table end pc", bus.o_pc, 32'h94);

        // Reset mid-cycle with an update and a redirect pending
        drive(0, 0, 0, 1, 32'h300, 1, 32'h94, 1, 32'h200);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset pc", bus.o_pc, 32'h0);
        chk("async reset pred_taken", 32'(bus.o_pred_taken), 32'h0);
        chk("async reset pred_target", bus.o_pred_target, 32'h4);
        tick();
        idle();
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 32'h50, 0, 0, 0, 0);
        tick();
        chk("post reset 0x50 pc", bus.o_pc, 32'h50);
        chk("post reset 0x50 cleared", 32'(bus.o_pred_taken), 32'h0);
        drive(0, 0, 0, 1, 32'h94, 0, 0, 0, 0);
        tick();
        chk("post reset 0x94 no stale update", 32'(bus.o_pred_taken), 32'h0);

        // Same-cycle update and lookup: new entry visible only after the edge
        drive(1, 0, 0, 0, 0, 1, 32'h94, 1, 32'h20);
        #1;
        chk("same-cycle old contents", 32'(bus.o_pred_taken), 32'h0);
        tick();
        idle();
        chk("same-cycle stall pc", bus.o_pc, 32'h94);
        chk("same-cycle new pred", 32'(bus.o_pred_taken), 32'h1);
        chk("same-cycle new target", bus.o_pred_target, 32'h20);
        tick();
        chk("predicted jump pc", bus.o_pc, 32'h20);

        // Upper saturation: 2 -> 3 -> 3 -> 3, then one not-taken keeps it taken
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 1, 32'h94, 1, 32'h20);
            tick();
        end
        drive(1, 0, 0, 0, 0, 1, 32'h94, 0, 0);
        tick();
        drive(0, 0, 0, 1, 32'h94, 0, 0, 0, 0);
        tick();
        chk("sat3 then nt pred", 32'(bus.o_pred_taken), 32'h1);
        drive(1, 0, 0, 0, 0, 1, 32'h94, 0, 0);
        tick();
        chk("sat3 two nt pred", 32'(bus.o_pred_taken), 32'h0);
        chk("sat3 two nt target", bus.o_pred_target, 32'h98);

        // XLEN wrap of the sequential increment
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tick();
        idle();
        chk("wrap pc", bus.o_pc, 32'hFFFF_FFFC);
        chk("wrap pc_four", bus.o_pc_four, 32'h0);
        chk("wrap pred_target", bus.o_pred_target, 32'h0);
        tick();
        chk("wrap next pc", bus.o_pc, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic        r_stall, r_tv, r_rv, r_uv, r_ut;
            logic [31:0] r_tpc, r_rpc, r_upc, r_utgt;
            chk("rand pc", bus.o_pc, m_pc);
            chk("rand pc_four", bus.o_pc_four, m_pc + 32'd4);
            chk("rand pred_taken", 32'(bus.o_pred_taken), 32'(mpred()));
            chk("rand pred_target", bus.o_pred_target,
                mpred() ? m_tgt[midx(m_pc)] : m_pc + 32'd4);
            r_stall = ($urandom_range(0, 99) < 20);
            r_tv    = ($urandom_range(0, 99) < 4);
            r_rv    = ($urandom_range(0, 99) < 15);
            r_uv    = ($urandom_range(0, 99) < 40);
            r_ut    = ($urandom_range(0, 99) < 60);
            r_tpc   = 32'($urandom_range(0, 255));
            r_rpc   = 32'($urandom_range(0, 255));
            r_upc   = ($urandom_range(0, 1) == 0) ? m_pc : 32'($urandom_range(0, 255));
            r_utgt  = 32'($urandom_range(0, 255)) & 32'hFFFF_FFFC;
            drive(r_stall, r_tv, r_tpc, r_rv, r_rpc, r_uv, r_upc, r_ut, r_utgt);
            model_step(r_stall, r_tv, r_tpc, r_rv, r_rpc, r_uv, r_upc, r_ut, r_utgt);
            tick();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen_btb.md
Name: pc_gen_btb

Overview:
- Parametrised fetch-stage PC generator; successor to the single-mux PC register.
- Adds a reset vector, prioritised redirect sources (trap, EX-stage redirect) and a direct-mapped branch target buffer (BTB) with 2-bit counters for next-PC prediction.
- Sits at the head of the IF stage.
- o_pc drives instruction memory. o_pred_taken and o_pred_target travel down the pipe so EX can detect mispredicts and issue i_redirect.

Parameters:
- XLEN, 32, PC and target width.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, BTB depth. Power of two, minimum 2.
- INSTR_BYTES, 4, sequential increment. Also sets the count of ignored low PC bits: OFF_W = log2(INSTR_BYTES).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_stall_f  in  1  hold PC (fetch stall).
- i_trap_valid  in  1  trap/exception redirect request.
- i_trap_pc  in  XLEN  trap handler address.
- i_redirect_valid  in  1  EX-stage redirect (mispredict or resolved jump).
- i_redirect_pc  in  XLEN  correct next PC.
- i_upd_valid  in  1  BTB update from a resolved branch/jump.
- i_upd_pc  in  XLEN  PC of the resolved branch.
- i_upd_taken  in  1  resolved direction.
- i_upd_target  in  XLEN  resolved target.
- o_pc  out  XLEN  current fetch PC.
- o_pc_four  out  XLEN  o_pc + INSTR_BYTES.
- o_pred_taken  out  1  BTB predicts o_pc taken.
- o_pred_target  out  XLEN  predicted target. Equals o_pc_four when o_pred_taken is 0.

Behaviour:
- Single clock i_clk. Reset i_rst is asynchronous and active-low.
- On reset:
  - o_pc = RESET_VEC.
  - All BTB valid bits cleared; tags, targets and counters are don't-care.
  - Consequently o_pred_taken = 0 and o_pred_target = RESET_VEC + INSTR_BYTES.
- BTB addressing:
  - index = pc[OFF_W+IDX_W-1:OFF_W], where IDX_W = log2(BTB_ENTRIES).
  - tag = pc[XLEN-1:OFF_W+IDX_W].
  - Entry fields: valid, tag, target, ctr[1:0].
- Lookup: combinational on o_pc. o_pred_taken = valid & tag match & ctr[1].
- Next-PC selection, registered on the rising edge, priority high to low:
  1. i_trap_valid -> i_trap_pc
  2. i_redirect_valid -> i_redirect_pc
  3. i_stall_f -> hold o_pc
  4. o_pred_taken -> BTB target
  5. otherwise -> o_pc_four
- Trap and redirect override stall. Latency from any redirect input to o_pc is exactly 1 cycle.
- Redirect PCs are used unmodified. Low OFF_W bits are ignored for indexing only.
- o_pc_four uses XLEN-bit modulo addition: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- BTB update, on the rising edge when i_upd_valid is 1, at the index of i_upd_pc:
  - Hit (valid & tag match), taken: ctr saturating increment (max 3); target <= i_upd_target.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate/replace. valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- Update is independent of stall, trap and redirect.
- Same-cycle update and lookup on the same index: lookup sees the old contents; the new contents are visible the next cycle.
- Reset asserted mid-operation: PC and valid bits clear immediately, regardless of pending update or redirect.
- No X on outputs after reset.

Decomposition:
- Package pc_gen_pkg:
  - localparam XLEN default.
  - typedef ctr_t (2-bit counter), with constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - typedef btb_entry_t struct: valid, tag, target, ctr.
  - function ctr_next(ctr, taken), the saturating counter update.
- Sub-module btb_dm:
  - Holds storage, lookup port and update port. Parametrised by XLEN, BTB_ENTRIES and INSTR_BYTES.
  - pc_gen_btb keeps the PC register and the priority mux.

Test Plan:
1. Reset, then 3 cycles with no inputs -> o_pc = 0, 4, 8; o_pred_taken = 0 throughout.
2. Stall at o_pc=8 for 2 cycles, with i_redirect_valid=1 and i_redirect_pc=0x100 in the second stall cycle -> o_pc = 8, 8, then 0x100 on the next cycle.
3. Trap and redirect in the same cycle (trap_pc=0x80, redirect_pc=0x200) -> next o_pc = 0x80.
4. Update pc=0x10, taken, target=0x40, then fetch reaches 0x10 -> o_pred_taken=1, o_pred_target=0x40, next o_pc=0x40.
5. Same entry with two not-taken updates (ctr 2->1->0) -> at 0x10, o_pred_taken=0 and next o_pc=0x14. Third not-taken update -> ctr stays 0.
6. Alias pc=0x50 with BTB_ENTRIES=16 (same index as 0x10, different tag), taken to 0x90 -> entry replaced; fetch at 0x10 predicts not taken; reset mid-run returns o_pc to 0 and clears all predictions.
